icache_assoc_prefetch: RTL and testbench

- Parametrised successor to the fixed 2-way instruction cache: N-way set-associative, true-LRU replacement, configurable sequential/branch-target prefetch window.
- Explicit MSHR table tracks outstanding memory tags.
- Sits between the fetch stage and the instruction-memory bus: serves 64-bit blocks combinationally on hit and issues at most one BUS_LOAD per cycle.

---
 rtl/icache_assoc_prefetch.sv | 213 +++++++++++++++++++++
 tb/tb_icache_assoc_prefetch.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/icache_assoc_prefetch.sv
// N-way set-associative instruction cache with true-LRU replacement,
// a sequential/branch-target prefetch window and an explicit MSHR table.
module icache_assoc_prefetch #(
    parameter int NUM_SETS       = 16,
    parameter int NUM_WAYS       = 2,
    parameter int PREFETCH_DEPTH = 4,
    parameter int NUM_MSHR       = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        squash,
    input  logic [3:0]  Imem2proc_response,
    input  logic [63:0] Imem2proc_data,
    input  logic [3:0]  Imem2proc_tag,
    input  logic [31:0] proc2Icache_addr,
    input  logic        early_branch_valid,
    input  logic [12:0] early_branch_target,
    output logic [1:0]  proc2Imem_command,
    output logic [31:0] proc2Imem_addr,
    output logic [63:0] Icache_data_out,
    output logic        Icache_valid_out
);

    localparam int IDX_W  = $clog2(NUM_SETS);
    localparam int TAG_W  = 13 - IDX_W;
    localparam int WAY_W  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
    localparam int MSHR_W = (NUM_MSHR > 1) ? $clog2(NUM_MSHR) : 1;
    localparam logic [1:0] BUS_NONE = 2'd0;
    localparam logic [1:0] BUS_LOAD = 2'd1;

    typedef logic [NUM_WAYS-1:0][WAY_W-1:0] ages_t;

    logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
    logic [TAG_W-1:0]    tag_q   [NUM_SETS][NUM_WAYS];
    logic [63:0]         data_q  [NUM_SETS][NUM_WAYS];
    ages_t               age_q   [NUM_SETS];
    logic [NUM_MSHR-1:0] mv_q;
    logic [12:0]         mba_q   [NUM_MSHR];
    logic [3:0]          mtag_q  [NUM_MSHR];
    logic [12:0]         last_ba_q, last_ba_d;

    logic [12:0]         ba;
    logic [12:0]         cand [PREFETCH_DEPTH];
    logic [PREFETCH_DEPTH-1:0] cand_hit, cand_inm;
    logic                sel_found;
    logic [12:0]         sel_ba;
    logic [IDX_W-1:0]    dem_idx;
    logic                dem_hit;
    logic [WAY_W-1:0]    dem_way;
    logic                free_found;
    logic [MSHR_W-1:0]   free_idx;
    logic                fill_hit;
    logic [MSHR_W-1:0]   fill_e;
    logic [12:0]         fill_ba;
    logic [IDX_W-1:0]    fill_idx;
    logic [TAG_W-1:0]    fill_tag;
    logic [WAY_W-1:0]    fill_way;
    logic                fill_found;
    logic                issue, alloc;
    ages_t               hit_age_d, fill_age_d, fill_base;

    function automatic ages_t touch(input ages_t a, input logic [WAY_W-1:0] w);
        ages_t r;
        r = a;
        for (int k = 0; k < NUM_WAYS; k++)
            if (a[k] < a[w]) r[k] = a[k] + 1'b1;
        r[w] = '0;
        return r;
    endfunction

    // Candidate window: demand block then sequential or branch-target blocks
    always_comb begin
        ba = proc2Icache_addr[15:3];
        for (int i = 0; i < PREFETCH_DEPTH; i++) begin
            if (i == 0)
                cand[i] = ba;
            else if (early_branch_valid)
                cand[i] = early_branch_target + 13'(i - 1);
            else
                cand[i] = ba + 13'(i);
        end
    end

    // Per-candidate cache and MSHR lookup, lowest fetchable one is selected
    always_comb begin
        cand_hit  = '0;
        cand_inm  = '0;
        sel_found = 1'b0;
        sel_ba    = cand[0];
        for (int i = 0; i < PREFETCH_DEPTH; i++) begin
            for (int w = 0; w < NUM_WAYS; w++)
                if (valid_q[cand[i][IDX_W-1:0]][w] &&
                    tag_q[cand[i][IDX_W-1:0]][w] == cand[i][12:IDX_W])
                    cand_hit[i] = 1'b1;
            for (int m = 0; m < NUM_MSHR; m++)
                if (mv_q[m] && mba_q[m] == cand[i])
                    cand_inm[i] = 1'b1;
            if (!sel_found && !cand_hit[i] && !cand_inm[i]) begin
                sel_found = 1'b1;
                sel_ba    = cand[i];
            end
        end
    end

    // Demand hit way and lowest free MSHR entry
    always_comb begin
        dem_idx    = ba[IDX_W-1:0];
        dem_hit    = 1'b0;
        dem_way    = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int w = 0; w < NUM_WAYS; w++)
            if (!dem_hit && valid_q[dem_idx][w] &&
                tag_q[dem_idx][w] == ba[12:IDX_W]) begin
                dem_hit = 1'b1;
                dem_way = WAY_W'(w);
            end
        for (int m = 0; m < NUM_MSHR; m++)
            if (!free_found && !mv_q[m]) begin
                free_found = 1'b1;
                free_idx   = MSHR_W'(m);
            end
    end

    // Fill matching and victim choice: present way, else invalid, else LRU
    always_comb begin
        fill_hit   = 1'b0;
        fill_e     = '0;
        for (int m = 0; m < NUM_MSHR; m++)
            if (!fill_hit && Imem2proc_tag != 4'd0 && mv_q[m] &&
                mtag_q[m] == Imem2proc_tag) begin
                fill_hit = 1'b1;
                fill_e   = MSHR_W'(m);
            end
        fill_ba    = mba_q[fill_e];
        fill_idx   = fill_ba[IDX_W-1:0];
        fill_tag   = fill_ba[12:IDX_W];
        fill_found = 1'b0;
        fill_way   = '0;
        for (int w = 0; w < NUM_WAYS; w++)
            if (!fill_found && valid_q[fill_idx][w] && tag_q[fill_idx][w] == fill_tag) begin
                fill_found = 1'b1;
                fill_way   = WAY_W'(w);
            end
        for (int w = 0; w < NUM_WAYS; w++)
            if (!fill_found && !valid_q[fill_idx][w]) begin
                fill_found = 1'b1;
                fill_way   = WAY_W'(w);
            end
        for (int w = 0; w < NUM_WAYS; w++)
            if (!fill_found && age_q[fill_idx][w] == WAY_W'(NUM_WAYS - 1)) begin
                fill_found = 1'b1;
                fill_way   = WAY_W'(w);
            end
    end

    // LRU next state: hit touch first, fill touch last so the fill ends MRU
    always_comb begin
        hit_age_d = age_q[dem_idx];
        if (dem_hit) hit_age_d = touch(age_q[dem_idx], dem_way);
        fill_base = (dem_hit && fill_idx == dem_idx) ? hit_age_d : age_q[fill_idx];
        fill_age_d = touch(fill_base, fill_way);
    end

    assign issue     = sel_found && free_found && (ba == last_ba_q);
    assign alloc     = issue && (Imem2proc_response != 4'd0);
    assign last_ba_d = squash ? '1 : ba;

    assign proc2Imem_command = issue ? BUS_LOAD : BUS_NONE;
    assign proc2Imem_addr    = {16'b0, sel_ba, 3'b0};
    assign Icache_valid_out  = dem_hit;
    assign Icache_data_out   = dem_hit ? data_q[dem_idx][dem_way] : 64'd0;

    // Control state: valids, LRU ages, MSHR table and last block address
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                for (int w = 0; w < NUM_WAYS; w++)
                    age_q[s][w] <= WAY_W'(w);
            end
            for (int m = 0; m < NUM_MSHR; m++) begin
                mba_q[m]  <= '0;
                mtag_q[m] <= '0;
            end
            mv_q      <= '0;
            last_ba_q <= '1;
        end else begin
            last_ba_q <= last_ba_d;
            if (dem_hit)
                age_q[dem_idx] <= hit_age_d;
            if (fill_hit) begin
                valid_q[fill_idx][fill_way] <= 1'b1;
                age_q[fill_idx]             <= fill_age_d;
                mv_q[fill_e]                <= 1'b0;
            end
            if (alloc) begin
                mv_q[free_idx]   <= 1'b1;
                mba_q[free_idx]  <= sel_ba;
                mtag_q[free_idx] <= Imem2proc_response;
            end
        end
    end

    // Tag and data arrays need no reset; valid bits guard them
    always_ff @(posedge clock) begin
        if (fill_hit) begin
            tag_q[fill_idx][fill_way]  <= fill_tag;
            data_q[fill_idx][fill_way] <= Imem2proc_data;
        end
    end

endmodule

// File: tb/tb_icache_assoc_prefetch.sv
// Directed table-driven bench for icache_assoc_prefetch plus a hand-written
// reset-with-outstanding-miss sequence.
module tb_icache_assoc_prefetch;

    localparam logic [1:0] BN = 2'd0;
    localparam logic [1:0] BL = 2'd1;

    localparam logic [63:0] DA = 64'hDEAD_BEEF_0000_0001;
    localparam logic [63:0] D4 = 64'h0000_0004_CAFE_0004;
    localparam logic [63:0] D5 = 64'h0000_0005_CAFE_0005;
    localparam logic [63:0] D6 = 64'h0000_0006_CAFE_0006;
    localparam logic [63:0] D7 = 64'h0000_0007_CAFE_0007;
    localparam logic [63:0] D8 = 64'h0000_0008_CAFE_0008;
    localparam logic [63:0] A0 = 64'hA0A0_0000_1111_0000;
    localparam logic [63:0] A1 = 64'hA1A1_0000_2222_0001;
    localparam logic [63:0] A2 = 64'hA2A2_0000_3333_0002;

    logic        clock;
    logic        reset;
    logic        squash;
    logic [3:0]  Imem2proc_response;
    logic [63:0] Imem2proc_data;
    logic [3:0]  Imem2proc_tag;
    logic [31:0] proc2Icache_addr;
    logic        early_branch_valid;
    logic [12:0] early_branch_target;
    logic [1:0]  proc2Imem_command;
    logic [31:0] proc2Imem_addr;
    logic [63:0] Icache_data_out;
    logic        Icache_valid_out;

    int n_pass;
    int n_total;

    typedef struct {
        logic        rst;
        logic        sq;
        logic [31:0] addr;
        logic        eb;
        logic [12:0] tgt;
        logic [3:0]  resp;
        logic [3:0]  rtag;
        logic [63:0] rdata;
        logic [1:0]  ecmd;
        logic [31:0] eaddr;
        logic        evalid;
        logic [63:0] edata;
    } vec_t;

    vec_t vq[$];

    icache_assoc_prefetch dut (
        .clock               (clock),
        .reset               (reset),
        .squash              (squash),
        .Imem2proc_response  (Imem2proc_response),
        .Imem2proc_data      (Imem2proc_data),
        .Imem2proc_tag       (Imem2proc_tag),
        .proc2Icache_addr    (proc2Icache_addr),
        .early_branch_valid  (early_branch_valid),
        .early_branch_target (early_branch_target),
        .proc2Imem_command   (proc2Imem_command),
        .proc2Imem_addr      (proc2Imem_addr),
        .Icache_data_out     (Icache_data_out),
        .Icache_valid_out    (Icache_valid_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic vec_t mk(
        input logic rst, input logic sq, input logic [31:0] addr,
        input logic eb, input logic [12:0] tgt, input logic [3:0] resp,
        input logic [3:0] rtag, input logic [63:0] rdata,
        input logic [1:0] ecmd, input logic [31:0] eaddr,
        input logic evalid, input logic [63:0] edata);
        vec_t v;
        v.rst = rst; v.sq = sq; v.addr = addr; v.eb = eb; v.tgt = tgt;
        v.resp = resp; v.rtag = rtag; v.rdata = rdata; v.ecmd = ecmd;
        v.eaddr = eaddr; v.evalid = evalid; v.edata = edata;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            n_pass++;
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        reset = 1'b1;
        squash = 1'b0;
        Imem2proc_response = 4'd0;
        Imem2proc_data = 64'd0;
        Imem2proc_tag = 4'd0;
        proc2Icache_addr = 32'h100;
        early_branch_valid = 1'b0;
        early_branch_target = 13'd0;

        // cold miss, reject/reissue, prefetch window
        vq.push_back(mk(0,0,32'h100,0,13'h0,4'd0,4'd0,64'd0, BN,32'h100,0,64'd0));
        vq.push_back(mk(0,0,32'h100,0,13'h0,4'd3,4'd0,64'd0, BL,32'h100,0,64'd0));
        vq.push_back(mk(0,0,32'h100,0,13'h0,4'd0,4'd0,64'd0, BL,32'h108,0,64'd0));
        vq.push_back(mk(0,0,32'h100,0,13'h0,4'd0,4'd3,DA,    BL,32'h108,0,64'd0));
        vq.push_back(mk(0,0,32'h100,0,13'h0,4'd4,4'd0,64'd0, BL,32'h108,1,DA));
        vq.push_back(mk(0,0,32'h100,0,13'h0,4'd5,4'd0,64'd0, BL,32'h110,1,DA));
        vq.push_back(mk(0,0,32'h100,0,13'h0,4'd6,4'd0,64'd0, BL,32'h118,1,DA));
        vq.push_back(mk(0,0,32'h100,0,13'h0,4'd0,4'd0,64'd0, BN,32'h100,1,DA));
        // early branch, MSHR full, fill frees an entry
        vq.push_back(mk(0,0,32'h100,1,13'h040,4'd7,4'd0,64'd0, BL,32'h200,1,DA));
        vq.push_back(mk(0,0,32'h100,1,13'h040,4'd8,4'd0,64'd0, BN,32'h208,1,DA));
        vq.push_back(mk(0,0,32'h100,1,13'h040,4'd8,4'd4,D4,    BN,32'h208,1,DA));
        vq.push_back(mk(0,0,32'h100,1,13'h040,4'd8,4'd0,64'd0, BL,32'h208,1,DA));
        // drain outstanding fills
        vq.push_back(mk(0,0,32'h100,0,13'h0,4'd0,4'd5,D5, BN,32'h100,1,DA));
        vq.push_back(mk(0,0,32'h100,0,13'h0,4'd0,4'd6,D6, BN,32'h100,1,DA));
        vq.push_back(mk(0,0,32'h100,0,13'h0,4'd0,4'd7,D7, BN,32'h100,1,DA));
        vq.push_back(mk(0,0,32'h100,0,13'h0,4'd0,4'd8,D8, BN,32'h100,1,DA));
        vq.push_back(mk(0,0,32'h108,0,13'h0,4'd0,4'd0,64'd0, BN,32'h120,1,D4));
        vq.push_back(mk(0,0,32'h200,0,13'h0,4'd0,4'd0,64'd0, BN,32'h210,1,D7));
        // reset, then LRU eviction in set 0
        vq.push_back(mk(1,0,32'h000,0,13'h0,4'd0,4'd0,64'd0, BN,32'h000,0,64'd0));
        vq.push_back(mk(0,0,32'h000,0,13'h0,4'd0,4'd0,64'd0, BN,32'h000,0,64'd0));
        vq.push_back(mk(0,0,32'h000,0,13'h0,4'd1,4'd0,64'd0, BL,32'h000,0,64'd0));
        vq.push_back(mk(0,0,32'h000,0,13'h0,4'd0,4'd1,A0,    BL,32'h008,0,64'd0));
        vq.push_back(mk(0,0,32'h080,0,13'h0,4'd0,4'd0,64'd0, BN,32'h080,0,64'd0));
        vq.push_back(mk(0,0,32'h080,0,13'h0,4'd3,4'd0,64'd0, BL,32'h080,0,64'd0));
        vq.push_back(mk(0,0,32'h080,0,13'h0,4'd0,4'd3,A1,    BL,32'h088,0,64'd0));
        vq.push_back(mk(0,0,32'h000,0,13'h0,4'd0,4'd0,64'd0, BN,32'h008,1,A0));
        vq.push_back(mk(0,0,32'h100,0,13'h0,4'd0,4'd0,64'd0, BN,32'h100,0,64'd0));
        vq.push_back(mk(0,0,32'h100,0,13'h0,4'd4,4'd0,64'd0, BL,32'h100,0,64'd0));
        vq.push_back(mk(0,0,32'h100,0,13'h0,4'd0,4'd4,A2,    BL,32'h108,0,64'd0));
        vq.push_back(mk(0,0,32'h100,0,13'h0,4'd0,4'd0,64'd0, BL,32'h108,1,A2));
        vq.push_back(mk(0,0,32'h000,0,13'h0,4'd0,4'd0,64'd0, BN,32'h008,1,A0));
        vq.push_back(mk(0,0,32'h080,0,13'h0,4'd0,4'd0,64'd0, BN,32'h080,0,64'd0));
        // squash costs one issue cycle
        vq.push_back(mk(0,1,32'h080,0,13'h0,4'd0,4'd0,64'd0, BL,32'h080,0,64'd0));
        vq.push_back(mk(0,0,32'h080,0,13'h0,4'd0,4'd0,64'd0, BN,32'h080,0,64'd0));
        vq.push_back(mk(0,0,32'h080,0,13'h0,4'd9,4'd0,64'd0, BL,32'h080,0,64'd0));

        @(negedge clock);
        chk("reset_cmd", 64'(proc2Imem_command), 64'(BN));
        chk("reset_valid", 64'(Icache_valid_out), 64'd0);
        chk("reset_data", Icache_data_out, 64'd0);

        for (int i = 0; i < vq.size(); i++) begin
            @(posedge clock);
            #1;
            reset               = vq[i].rst;
            squash              = vq[i].sq;
            proc2Icache_addr    = vq[i].addr;
            early_branch_valid  = vq[i].eb;
            early_branch_target = vq[i].tgt;
            Imem2proc_response  = vq[i].resp;
            Imem2proc_tag       = vq[i].rtag;
            Imem2proc_data      = vq[i].rdata;
            @(negedge clock);
            chk($sformatf("v%0d_cmd", i), 64'(proc2Imem_command), 64'(vq[i].ecmd));
            chk($sformatf("v%0d_addr", i), 64'(proc2Imem_addr), 64'(vq[i].eaddr));
            chk($sformatf("v%0d_valid", i), 64'(Icache_valid_out), 64'(vq[i].evalid));
            chk($sformatf("v%0d_data", i), Icache_data_out, vq[i].edata);
        end

        // reset with MSHR entry (tag 9) outstanding; late tag must not fill
        @(posedge clock);
        #1;
        proc2Icache_addr   = 32'h100;
        Imem2proc_response = 4'd0;
        Imem2proc_tag      = 4'd0;
        squash             = 1'b0;
        @(negedge clock);
        chk("pre_rst_valid", 64'(Icache_valid_out), 64'd1);
        chk("pre_rst_data", Icache_data_out, A2);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_cmd", 64'(proc2Imem_command), 64'(BN));
        chk("async_rst_valid", 64'(Icache_valid_out), 64'd0);
        chk("async_rst_data", Icache_data_out, 64'd0);
        @(posedge clock);
        #1;
        reset            = 1'b0;
        proc2Icache_addr = 32'h080;
        Imem2proc_tag    = 4'd9;
        Imem2proc_data   = 64'hBAD0_BAD0_BAD0_BAD0;
        @(negedge clock);
        chk("post_rst_first_cmd", 64'(proc2Imem_command), 64'(BN));
        @(posedge clock);
        #1;
        Imem2proc_tag  = 4'd0;
        Imem2proc_data = 64'd0;
        @(negedge clock);
        chk("late_tag_valid", 64'(Icache_valid_out), 64'd0);
        chk("late_tag_data", Icache_data_out, 64'd0);
        chk("post_rst_cmd", 64'(proc2Imem_command), 64'(BL));
        chk("post_rst_addr", 64'(proc2Imem_addr), 64'h080);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
